// File: rtl/conv_stream_scheduler_pkg.sv
// Shared types and helpers for the convolution stream scheduler.
//   state_t  : scheduler FSM states (IDLE, RUN, FLUSH)
//   cs_log2  : coordinate width for a given image edge (minimum 1 bit)
package conv_stream_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  function automatic int unsigned cs_log2(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_stream_scheduler_if.sv
// Handshake bundle between the scheduler and its environment.
//   start       : frame start request (sampled in IDLE)
//   in_valid    : upstream pixel present          in_ready   : pixel accepted this cycle
//   conv_clk_en : datapath clock enable           out_valid  : window result valid
//   out_ready   : downstream consumes result      out_row/col: output-map coordinates
//   busy        : scheduler not idle              frame_done : one-cycle frame completion pulse
// slave modport = scheduler side, master modport = environment side.
interface conv_stream_scheduler_if
  import conv_stream_scheduler_pkg::*;
#(
  parameter int unsigned IMAGE_SIZE = 28
) ();
  localparam int unsigned W = cs_log2(IMAGE_SIZE);

  logic         start;
  logic         in_valid;
  logic         in_ready;
  logic         conv_clk_en;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_row;
  logic [W-1:0] out_col;
  logic         busy;
  logic         frame_done;

  modport slave (
    input  start, in_valid, out_ready,
    output in_ready, conv_clk_en, out_valid, out_row, out_col, busy, frame_done
  );

  modport master (
    output start, in_valid, out_ready,
    input  in_ready, conv_clk_en, out_valid, out_row, out_col, busy, frame_done
  );
endinterface

// File: rtl/conv_stream_scheduler_stride_counter.sv
// Position counter along one image axis with stride phase and output index.
//   clk, rst : clock, async active-high reset
//   clr_i    : restart at position 0
//   step_i   : advance one position (wraps to 0 after SIZE-1)
//   idx_o    : output-map index (pos-FILTER+1)/STRIDE, valid while hit_o
//   last_o   : position is SIZE-1
//   hit_o    : position completes a window along this axis
module stride_counter #(
  parameter int unsigned SIZE   = 28,
  parameter int unsigned FILTER = 3,
  parameter int unsigned STRIDE = 1,
  parameter int unsigned W      = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         step_i,
  output logic [W-1:0] idx_o,
  output logic         last_o,
  output logic         hit_o
);
  localparam int unsigned PW = (STRIDE > 1) ? $clog2(STRIDE) : 1;

  logic [W-1:0]  pos_q, pos_d;
  logic [W-1:0]  idx_q, idx_d;
  logic [PW-1:0] ph_q, ph_d;

  assign last_o = (pos_q == W'(SIZE - 1));
  assign hit_o  = (pos_q >= W'(FILTER - 1)) && (ph_q == '0);
  assign idx_o  = idx_q;

  // Phase and index only start moving once the first full window along
  // this axis has been reached, so phase==0 marks stride-aligned positions.
  always_comb begin
    pos_d = pos_q;
    idx_d = idx_q;
    ph_d  = ph_q;
    if (clr_i) begin
      pos_d = '0;
      idx_d = '0;
      ph_d  = '0;
    end else if (step_i) begin
      if (last_o) begin
        pos_d = '0;
        idx_d = '0;
        ph_d  = '0;
      end else begin
        pos_d = W'(pos_q + 1'b1);
        if (pos_q >= W'(FILTER - 1)) begin
          if (ph_q == PW'(STRIDE - 1)) begin
            ph_d  = '0;
            idx_d = W'(idx_q + 1'b1);
          end else begin
            ph_d  = PW'(ph_q + 1'b1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_q <= '0;
      idx_q <= '0;
      ph_q  <= '0;
    end else begin
      pos_q <= pos_d;
      idx_q <= idx_d;
      ph_q  <= ph_d;
    end
  end
endmodule

// File: rtl/conv_stream_scheduler.sv
// Raster-order pixel scheduler for a streaming convolution datapath.
// Accepts one pixel per in_valid&in_ready cycle, gates the datapath with
// conv_clk_en, and reports each completed (strided) window one cycle later
// with its output-map coordinates.
//   clk, rst : clock, async active-high reset
//   bus      : slave side of conv_stream_scheduler_if (start, pixel and result handshakes)
module conv_stream_scheduler
  import conv_stream_scheduler_pkg::*;
#(
  parameter int unsigned IMAGE_SIZE  = 28,
  parameter int unsigned FILTER_SIZE = 3,
  parameter int unsigned STRIDE      = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  conv_stream_scheduler_if.slave  bus
);
  localparam int unsigned W = cs_log2(IMAGE_SIZE);

  state_t       state_q, state_d;
  logic         ov_q, ov_d;
  logic [W-1:0] orow_q, orow_d;
  logic [W-1:0] ocol_q, ocol_d;
  logic         fd_q, fd_d;

  logic         in_ready;
  logic         accept;
  logic         clr;
  logic [W-1:0] row_idx, col_idx;
  logic         row_last, col_last;
  logic         row_hit, col_hit;

  // Holding off input while an unconsumed result sits on out_valid keeps the
  // datapath output frozen, so out_row/out_col need no separate hold logic.
  assign in_ready = (state_q == RUN) && (!ov_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  assign clr      = (state_q == IDLE) && bus.start;

  stride_counter #(
    .SIZE   (IMAGE_SIZE),
    .FILTER (FILTER_SIZE),
    .STRIDE (STRIDE),
    .W      (W)
  ) u_col (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (clr),
    .step_i (accept),
    .idx_o  (col_idx),
    .last_o (col_last),
    .hit_o  (col_hit)
  );

  stride_counter #(
    .SIZE   (IMAGE_SIZE),
    .FILTER (FILTER_SIZE),
    .STRIDE (STRIDE),
    .W      (W)
  ) u_row (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (clr),
    .step_i (accept && col_last),
    .idx_o  (row_idx),
    .last_o (row_last),
    .hit_o  (row_hit)
  );

  always_comb begin
    state_d = state_q;
    ov_d    = ov_q;
    orow_d  = orow_q;
    ocol_d  = ocol_q;
    fd_d    = 1'b0;

    // A new window result takes priority over consumption of the old one.
    if (accept && row_hit && col_hit) begin
      ov_d   = 1'b1;
      orow_d = row_idx;
      ocol_d = col_idx;
    end else if (ov_q && bus.out_ready) begin
      ov_d   = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (bus.start) state_d = RUN;
      end
      RUN: begin
        if (accept && row_last && col_last) state_d = FLUSH;
      end
      FLUSH: begin
        if (!ov_q || bus.out_ready) begin
          state_d = IDLE;
          fd_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ov_q    <= 1'b0;
      orow_q  <= '0;
      ocol_q  <= '0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ov_q    <= ov_d;
      orow_q  <= orow_d;
      ocol_q  <= ocol_d;
      fd_q    <= fd_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.conv_clk_en = accept;
  assign bus.out_valid   = ov_q;
  assign bus.out_row     = orow_q;
  assign bus.out_col     = ocol_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.frame_done  = fd_q;
endmodule

// File: tb/tb_conv_stream_scheduler.sv
module tb_conv_stream_scheduler;
  import conv_stream_scheduler_pkg::*;

  localparam int IMG = 5;
  localparam int FS  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic start_s = 1'b0, in_valid_s = 1'b0, out_ready_s = 1'b0;

  conv_stream_scheduler_if #(.IMAGE_SIZE(IMG)) bus0 ();
  conv_stream_scheduler_if #(.IMAGE_SIZE(IMG)) bus1 ();

  assign bus0.start = start_s;  assign bus0.in_valid = in_valid_s;  assign bus0.out_ready = out_ready_s;
  assign bus1.start = start_s;  assign bus1.in_valid = in_valid_s;  assign bus1.out_ready = out_ready_s;

  conv_stream_scheduler #(.IMAGE_SIZE(IMG), .FILTER_SIZE(FS), .STRIDE(1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  conv_stream_scheduler #(.IMAGE_SIZE(IMG), .FILTER_SIZE(FS), .STRIDE(2)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  logic       d_ir[2], d_ce[2], d_ov[2], d_busy[2], d_fd[2];
  logic [2:0] d_or[2], d_oc[2];
  assign d_ir[0] = bus0.in_ready;    assign d_ir[1] = bus1.in_ready;
  assign d_ce[0] = bus0.conv_clk_en; assign d_ce[1] = bus1.conv_clk_en;
  assign d_ov[0] = bus0.out_valid;   assign d_ov[1] = bus1.out_valid;
  assign d_busy[0] = bus0.busy;      assign d_busy[1] = bus1.busy;
  assign d_fd[0] = bus0.frame_done;  assign d_fd[1] = bus1.frame_done;
  assign d_or[0] = bus0.out_row;     assign d_or[1] = bus1.out_row;
  assign d_oc[0] = bus0.out_col;     assign d_oc[1] = bus1.out_col;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: frame phase (0 idle, 1 run, 2 flush), accepted pixel
  // count, and the pending result; pixel position is n/IMG, n%IMG.
  int strd[2] = '{1, 2};
  int m_st[2] = '{0, 0};
  int m_n[2]  = '{0, 0};
  int m_or[2] = '{0, 0};
  int m_oc[2] = '{0, 0};
  bit m_ov[2] = '{0, 0};
  bit m_fd[2] = '{0, 0};
  int m_cnt[2] = '{0, 0};

  function automatic void mstep(int k);
    bit rdy, acc, cons, win;
    int r, c, s;
    s = strd[k];
    m_fd[k] = 1'b0;
    rdy  = (m_st[k] == 1) && (!m_ov[k] || out_ready_s);
    acc  = rdy && in_valid_s;
    cons = m_ov[k] && out_ready_s;
    case (m_st[k])
      0: if (start_s) begin m_st[k] = 1; m_n[k] = 0; end
      1: begin
        if (cons) begin m_cnt[k]++; m_ov[k] = 1'b0; end
        if (acc) begin
          r = m_n[k] / IMG;
          c = m_n[k] % IMG;
          win = (r >= FS-1) && (c >= FS-1) && ((r-FS+1) % s == 0) && ((c-FS+1) % s == 0);
          if (win) begin m_ov[k] = 1'b1; m_or[k] = (r-FS+1)/s; m_oc[k] = (c-FS+1)/s; end
          m_n[k]++;
          if (m_n[k] == IMG*IMG) m_st[k] = 2;
        end
      end
      default: if (!m_ov[k] || out_ready_s) begin
        if (m_ov[k]) m_cnt[k]++;
        m_ov[k] = 1'b0; m_st[k] = 0; m_fd[k] = 1'b1;
      end
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_st[k] = 0; m_n[k] = 0; m_or[k] = 0; m_oc[k] = 0; m_ov[k] = 1'b0; m_fd[k] = 1'b0;
      end else begin
        mstep(k);
      end
    end
  end

  // DUT-side observations for literal per-frame checks.
  int dres0[$], dres1[$];
  int dacc[2], first_n[2], fd_cnt[2];

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      bit mrdy;
      mrdy = (m_st[k] == 1) && (!m_ov[k] || out_ready_s);
      check($sformatf("in_ready%0d", k), int'(d_ir[k]), int'(mrdy));
      check($sformatf("conv_clk_en%0d", k), int'(d_ce[k]), int'(mrdy && in_valid_s));
      check($sformatf("out_valid%0d", k), int'(d_ov[k]), int'(m_ov[k]));
      check($sformatf("busy%0d", k), int'(d_busy[k]), int'(m_st[k] != 0));
      check($sformatf("frame_done%0d", k), int'(d_fd[k]), int'(m_fd[k]));
      if (m_ov[k]) begin
        check($sformatf("out_row%0d", k), int'(d_or[k]), m_or[k]);
        check($sformatf("out_col%0d", k), int'(d_oc[k]), m_oc[k]);
      end
      if (!rst) begin
        if (d_ce[k]) dacc[k]++;
        if (d_ov[k] && first_n[k] < 0) first_n[k] = dacc[k] - (d_ce[k] ? 1 : 0);
        if (d_fd[k]) fd_cnt[k]++;
        if (d_ov[k] && out_ready_s) begin
          if (k == 0) dres0.push_back(int'(d_or[k]) * 16 + int'(d_oc[k]));
          else        dres1.push_back(int'(d_or[k]) * 16 + int'(d_oc[k]));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_frame();
    dres0.delete(); dres1.delete();
    for (int k = 0; k < 2; k++) begin
      dacc[k] = 0; first_n[k] = -1; fd_cnt[k] = 0; m_cnt[k] = 0;
    end
  endtask

  // Runs one frame to completion; stall=1 holds out_ready low for 5 cycles
  // right after the first result appears.
  task automatic run_frame(input int iv_pct, input int or_pct, input bit stray, input bit stall);
    int  cyc;
    bit  stalled;
    clear_frame();
    stalled = 1'b0;
    start_s = 1'b1; in_valid_s = 1'b0; out_ready_s = 1'b1;
    tick();
    start_s = 1'b0;
    cyc = 0;
    while (!(m_st[0] == 0 && m_st[1] == 0) && cyc < 3000) begin
      if (stall && !stalled && d_ov[0]) begin
        stalled = 1'b1;
        in_valid_s = 1'b1; out_ready_s = 1'b0;
        repeat (5) begin
          tick();
          check("stall_in_ready", int'(d_ir[0]), 0);
          check("stall_clk_en", int'(d_ce[0]), 0);
          check("stall_out_valid", int'(d_ov[0]), 1);
          check("stall_row", int'(d_or[0]), 0);
          check("stall_col", int'(d_oc[0]), 0);
        end
        check("stall_accepts", dacc[0], 13);
      end
      in_valid_s  = ($urandom_range(99) < iv_pct);
      out_ready_s = ($urandom_range(99) < or_pct);
      start_s     = stray && (m_st[0] != 0) && (m_st[1] != 0) && ($urandom_range(3) == 0);
      tick();
      cyc++;
    end
    start_s = 1'b0; in_valid_s = 1'b0; out_ready_s = 1'b1;
    check("frame_timeout", int'(cyc < 3000), 1);
    tick();
    tick();
  endtask

  task automatic check_frame(input bit continuous);
    check("s1_results", dres0.size(), 9);
    check("s2_results", dres1.size(), 4);
    check("s1_model_results", m_cnt[0], 9);
    check("s2_model_results", m_cnt[1], 4);
    for (int i = 0; i < dres0.size() && i < 9; i++)
      check($sformatf("s1_coord%0d", i), dres0[i], (i / 3) * 16 + (i % 3));
    for (int i = 0; i < dres1.size() && i < 4; i++)
      check($sformatf("s2_coord%0d", i), dres1[i], (i / 2) * 16 + (i % 2));
    check("s1_accepts", dacc[0], 25);
    check("s2_accepts", dacc[1], 25);
    check("s1_frame_done", fd_cnt[0], 1);
    check("s2_frame_done", fd_cnt[1], 1);
    if (continuous) begin
      check("s1_first_valid_after", first_n[0], 13);
      check("s2_first_valid_after", first_n[1], 13);
    end
  endtask

  initial begin
    clear_frame();
    #12;
    check("rst_out_valid", int'(d_ov[0]), 0);
    check("rst_in_ready", int'(d_ir[0]), 0);
    check("rst_busy", int'(d_busy[1]), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick();

    // Free-running stream.
    run_frame(100, 100, 1'b0, 1'b0);
    check_frame(1'b1);

    // Downstream stall right after the first result.
    run_frame(100, 100, 1'b0, 1'b1);
    check_frame(1'b1);

    // 50% in_valid, full out_ready, stray start requests mid-frame.
    run_frame(50, 100, 1'b1, 1'b0);
    check_frame(1'b0);

    // Random in_valid and out_ready.
    for (int f = 0; f < 3; f++) begin
      run_frame(50, 60, 1'b1, 1'b0);
      check_frame(1'b0);
    end

    // Reset in the middle of a frame after 12 accepted pixels.
    begin
      int cyc;
      clear_frame();
      start_s = 1'b1; in_valid_s = 1'b0; out_ready_s = 1'b1;
      tick();
      start_s = 1'b0; in_valid_s = 1'b1;
      cyc = 0;
      while (m_n[0] < 12 && cyc < 100) begin
        tick();
        cyc++;
      end
      check("pre_reset_accepts", m_n[0], 12);
      rst = 1'b1;
      #1;
      for (int k = 0; k < 2; k++) begin
        check($sformatf("midrst_out_valid%0d", k), int'(d_ov[k]), 0);
        check($sformatf("midrst_in_ready%0d", k), int'(d_ir[k]), 0);
        check($sformatf("midrst_clk_en%0d", k), int'(d_ce[k]), 0);
        check($sformatf("midrst_busy%0d", k), int'(d_busy[k]), 0);
        check($sformatf("midrst_row%0d", k), int'(d_or[k]), 0);
        check($sformatf("midrst_col%0d", k), int'(d_oc[k]), 0);
        check($sformatf("midrst_fd%0d", k), int'(d_fd[k]), 0);
      end
      tick();
      tick();
      rst = 1'b0;
      in_valid_s = 1'b0;
      tick();
      run_frame(100, 100, 1'b0, 1'b0);
      check_frame(1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
